// File: rtl/brv32p_muldiv_seq.sv
// rtl/brv32p_muldiv_seq.sv - M-extension sequencer: registered 33x33 multiply, iterative restoring divide
// RISC-V divide corner cases resolve at start; a same-operand DIV/REM pair reuses the stored q/r.
module brv32p_muldiv_seq #(
  parameter int DIV_UNROLL = 1,
  parameter bit FUSE_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int ITER = 32 / DIV_UNROLL;
  localparam int CW   = $clog2(ITER) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(ITER);
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [31:0]   pend_q, pend_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qneg_q, qneg_d, rneg_q, rneg_d;
  logic          tag_vld_q, tag_vld_d, tag_sgn_q, tag_sgn_d;
  logic [31:0]   tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic [31:0]   tag_quo_q, tag_quo_d, tag_rem_q, tag_rem_d;

  logic               accept, in_sgn, in_rem, fuse_hit;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic [31:0]        div_r, div_q, fix_q, fix_r;
  logic [32:0]        div_sh, div_diff;

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE) && !kill;
  // pend holds the new value during the DONE cycle; result_q keeps the last delivered one
  assign result = done ? pend_q : result_q;

  assign accept   = start && !kill && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign in_sgn   = !op[0];
  assign in_rem   = op[1];
  assign fuse_hit = FUSE_EN && tag_vld_q && (tag_sgn_q == in_sgn) &&
                    (a == tag_a_q) && (b == tag_b_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    pend_d    = pend_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    tag_vld_d = tag_vld_q;
    tag_sgn_d = tag_sgn_q;
    tag_a_d   = tag_a_q;
    tag_b_d   = tag_b_q;
    tag_quo_d = tag_quo_q;
    tag_rem_d = tag_rem_q;

    mul_a    = {((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[31], a_q};
    mul_b    = {(op_q == OP_MULH) && b_q[31], b_q};
    prod     = mul_a * mul_b;
    fix_q    = qneg_q ? -quo_q : quo_q;
    fix_r    = rneg_q ? -rem_q : rem_q;
    div_r    = rem_q;
    div_q    = quo_q;
    div_sh   = '0;
    div_diff = '0;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      div_sh   = {div_r, div_q[31]};
      div_diff = div_sh - {1'b0, dvs_q};
      div_q    = {div_q[30:0], !div_diff[32]};
      div_r    = div_diff[32] ? div_sh[31:0] : div_diff[31:0];
    end

    if (done) result_d = pend_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          if (!op[2]) begin
            state_d = S_MUL;
          end else if (b == 32'd0) begin
            pend_d  = in_rem ? a : 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else if (in_sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            pend_d  = in_rem ? 32'd0 : 32'h8000_0000;
            state_d = S_DONE;
          end else if (fuse_hit) begin
            pend_d  = in_rem ? tag_rem_q : tag_quo_q;
            state_d = S_DONE;
          end else begin
            quo_d   = (in_sgn && a[31]) ? -a : a;
            dvs_d   = (in_sgn && b[31]) ? -b : b;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = in_sgn && (a[31] ^ b[31]);
            rneg_d  = in_sgn && a[31];
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        pend_d  = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
        state_d = S_DONE;
      end
      S_DIV: begin
        quo_d = div_q;
        rem_d = div_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_LIMIT) state_d = S_FIX;
      end
      S_FIX: begin
        pend_d    = op_q[1] ? fix_r : fix_q;
        tag_vld_d = 1'b1;
        tag_sgn_d = !op_q[0];
        tag_a_d   = a_q;
        tag_b_d   = b_q;
        tag_quo_d = fix_q;
        tag_rem_d = fix_r;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d   = S_IDLE;
      tag_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      pend_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      tag_vld_q <= 1'b0;
      tag_sgn_q <= 1'b0;
      tag_a_q   <= '0;
      tag_b_q   <= '0;
      tag_quo_q <= '0;
      tag_rem_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      pend_q    <= pend_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      tag_vld_q <= tag_vld_d;
      tag_sgn_q <= tag_sgn_d;
      tag_a_q   <= tag_a_d;
      tag_b_q   <= tag_b_d;
      tag_quo_q <= tag_quo_d;
      tag_rem_q <= tag_rem_d;
    end
  end

endmodule
